// File: rtl/doorlock_guard.sv
// Supervisor for the doorlock FSM: opens the door on success, counts consecutive
// failures, and enforces a timed, blinking lockout while gating the user's start.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for an ok/fail edge; start follows start_req
// S_OPEN | door actuator on for OPEN_CYC cycles; start gated
// S_LOCK | lockout for LOCK_CYC cycles with blinking alarm; start gated
module doorlock_guard #(
  parameter int MAX_FAIL   = 3,
  parameter int OPEN_CYC   = 8,
  parameter int LOCK_CYC   = 16,
  parameter int BLINK_HALF = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_req,
  input  logic       ok,
  input  logic       fail,
  output logic       start,
  output logic       door_open,
  output logic       locked,
  output logic       alarm,
  output logic [3:0] fail_cnt
);

  localparam logic [3:0] MAX_FAIL_W   = 4'(MAX_FAIL);
  localparam logic [7:0] OPEN_CYC_W   = 8'(OPEN_CYC);
  localparam logic [7:0] LOCK_CYC_W   = 8'(LOCK_CYC);
  localparam logic [7:0] BLINK_LAST_W = 8'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ok_q, fail_q;
  logic [7:0] timer_q, timer_d;
  logic [7:0] blink_q, blink_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic       alarm_q, alarm_d;
  logic       door_open_q, door_open_d;
  logic       locked_q, locked_d;
  logic       ok_rise, fail_rise;
  logic [3:0] cnt_inc;

  assign ok_rise   = ok & ~ok_q;
  assign fail_rise = fail & ~fail_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    blink_d    = blink_q;
    fail_cnt_d = fail_cnt_q;
    alarm_d    = alarm_q;
    cnt_inc    = fail_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        // a fail edge wins over a simultaneous ok edge
        if (fail_rise) begin
          fail_cnt_d = cnt_inc;
          if (cnt_inc == MAX_FAIL_W) begin
            state_d = S_LOCK;
            timer_d = LOCK_CYC_W;
            alarm_d = 1'b1;
            blink_d = 8'd0;
          end
        end else if (ok_rise) begin
          state_d    = S_OPEN;
          timer_d    = OPEN_CYC_W;
          fail_cnt_d = 4'd0;
        end
      end
      S_OPEN: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) state_d = S_IDLE;
      end
      S_LOCK: begin
        timer_d = timer_q - 8'd1;
        if (blink_q == BLINK_LAST_W) begin
          blink_d = 8'd0;
          alarm_d = ~alarm_q;
        end else begin
          blink_d = blink_q + 8'd1;
        end
        if (timer_q == 8'd1) begin
          state_d    = S_IDLE;
          fail_cnt_d = 4'd0;
          alarm_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    door_open_d = (state_d == S_OPEN);
    locked_d    = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      timer_q     <= 8'd0;
      blink_q     <= 8'd0;
      fail_cnt_q  <= 4'd0;
      alarm_q     <= 1'b0;
      door_open_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ok_q        <= ok;
      fail_q      <= fail;
      timer_q     <= timer_d;
      blink_q     <= blink_d;
      fail_cnt_q  <= fail_cnt_d;
      alarm_q     <= alarm_d;
      door_open_q <= door_open_d;
      locked_q    <= locked_d;
    end
  end

  // state_q is IDLE during reset, so start tracks start_req then too
  assign start     = (state_q == S_IDLE) & start_req;
  assign door_open = door_open_q;
  assign locked    = locked_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_cnt_q;

endmodule
